uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Two-requester arbiter in front of an 8N1 UART transmitter. One byte is
// accepted at a time, handed to the transmitter with a start request, and the
// arbiter waits for the transmitter's completion pulse (or a baud-tick based
// timeout) before accepting the next byte. With LOCK_EN set, a requester that
// starts a multi-byte message keeps the grant until its byte flagged "last"
// completes.
//
// Handshake: a byte moves from requester N on the rising edge where
// reqN_valid && reqN_ready are both high. reqN_ready is combinational, is only
// raised in IDLE for the currently selected requester while it is valid, and
// never depends on the other requester's ready. A requester may drop valid at
// any time before ready; nothing is captured in that case.
//
// Ports
//   hwclk        system clock, all logic on the rising edge
//   rst_n        asynchronous active-low reset
//   baud_tick    one-cycle pulse per bit period
//   reqN_valid   requester N offers a byte (N = 0, 1)
//   reqN_byte    offered byte
//   reqN_last    offered byte ends requester N's message
//   reqN_ready   byte accepted this cycle
//   tx_send      start request to the transmitter (registered)
//   tx_byte      byte presented to the transmitter (registered)
//   tx_done      one-cycle pulse from the transmitter at end of stop bit
//   grant        index of requester owning the current/last transfer
//   busy         high whenever the FSM is not IDLE
//   err_timeout  sticky flag: tx_done never arrived
//   err_clr      synchronous clear of err_timeout
//   dbg_state_o  current FSM state (0 IDLE, 1 SEND, 2 WAIT)
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int TIMEOUT_TICKS = 12,
  parameter bit LOCK_EN       = 1'b1
) (
  input  logic       hwclk,
  input  logic       rst_n,
  input  logic       baud_tick,
  input  logic       req0_valid,
  input  logic [7:0] req0_byte,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_byte,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       tx_send,
  output logic [7:0] tx_byte,
  input  logic       tx_done,
  output logic       grant,
  output logic       busy,
  output logic       err_timeout,
  input  logic       err_clr,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_TICKS);

  state_t     state_q;
  logic       tx_send_q;
  logic [7:0] tx_byte_q;
  logic       grant_q;
  logic       last_flag_q;
  logic       last_served_q;
  logic       lock_q;
  logic       err_q;
  logic [7:0] cnt_q;

  logic       sel;
  logic       sel_valid;
  logic       xfer;
  logic [7:0] cnt_inc;
  logic       timeout_hit;

  // Requester selection. While locked only the owner (the last grant) may be
  // picked, even if it is not currently valid, so the other side stalls.
  always_comb begin
    sel = 1'b0;
    if (lock_q) begin
      sel = grant_q;
    end else if (req0_valid && req1_valid) begin
      sel = ~last_served_q;
    end else if (req1_valid) begin
      sel = 1'b1;
    end
  end

  assign sel_valid = sel ? req1_valid : req0_valid;

  // rst_n is folded in so no ready can leak out while reset is held.
  assign xfer       = rst_n && (state_q == S_IDLE) && sel_valid;
  assign req0_ready = xfer && !sel;
  assign req1_ready = xfer && sel;

  // Counter value including this cycle's tick; the timeout therefore fires on
  // the edge of the TIMEOUT_TICKS-th tick seen in WAIT.
  assign cnt_inc     = (baud_tick && (cnt_q != 8'hFF)) ? cnt_q + 8'd1 : cnt_q;
  assign timeout_hit = (cnt_inc == TIMEOUT_CNT);

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      tx_send_q     <= 1'b0;
      tx_byte_q     <= 8'h00;
      grant_q       <= 1'b0;
      last_flag_q   <= 1'b0;
      last_served_q <= 1'b1;
      lock_q        <= 1'b0;
      err_q         <= 1'b0;
      cnt_q         <= 8'h00;
    end else begin
      // A timeout set below in the same cycle overrides this clear.
      if (err_clr) begin
        err_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (xfer) begin
            tx_byte_q   <= sel ? req1_byte : req0_byte;
            grant_q     <= sel;
            last_flag_q <= sel ? req1_last : req0_last;
            tx_send_q   <= 1'b1;
            state_q     <= S_SEND;
          end
        end
        S_SEND: begin
          if (baud_tick) begin
            tx_send_q <= 1'b0;
            cnt_q     <= 8'h00;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_inc;
          if (tx_done) begin
            // Completion wins over a coincident timeout.
            state_q       <= S_IDLE;
            last_served_q <= grant_q;
            lock_q        <= LOCK_EN && !last_flag_q;
          end else if (timeout_hit) begin
            state_q       <= S_IDLE;
            err_q         <= 1'b1;
            lock_q        <= 1'b0;
            last_served_q <= grant_q;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_send     = tx_send_q;
  assign tx_byte     = tx_byte_q;
  assign grant       = grant_q;
  assign busy        = (state_q != S_IDLE);
  assign err_timeout = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Requester drivers feed byte queues into the arbiter; a transmitter model
// answers tx_send with tx_done after a per-byte number of baud ticks (0 means
// never, forcing a timeout). A queue-level reference model decides the order
// in which bytes must be served and the error flag after each byte; a monitor
// pops those expectations whenever a transfer is observed.
// Expected-queue entry: [13:10] done delay, [9] err after byte,
// [8] grant, [7:0] byte.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int TIMEOUT = 12;
  localparam int W       = 14;
  localparam int LIMIT   = 40000;

  // ---------------- clock / reset / DUT ----------------
  logic       hwclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic       req0_valid = 1'b0, req0_last = 1'b0;
  logic       req1_valid = 1'b0, req1_last = 1'b0;
  logic [7:0] req0_byte = 8'h00, req1_byte = 8'h00;
  logic       req0_ready, req1_ready;
  logic       tx_send, grant, busy, err_timeout;
  logic [7:0] tx_byte;
  logic       tx_done = 1'b0;
  logic       err_clr_main = 1'b0, err_clr_tx = 1'b0;
  logic       err_clr;
  logic [1:0] dbg_state;

  assign err_clr = err_clr_main | err_clr_tx;

  always #5 hwclk = ~hwclk;

  uart_tx_arbiter #(.TIMEOUT_TICKS(TIMEOUT), .LOCK_EN(1'b1)) dut (
    .hwclk(hwclk), .rst_n(rst_n), .baud_tick(baud_tick),
    .req0_valid(req0_valid), .req0_byte(req0_byte), .req0_last(req0_last),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_byte(req1_byte), .req1_last(req1_last),
    .req1_ready(req1_ready),
    .tx_send(tx_send), .tx_byte(tx_byte), .tx_done(tx_done),
    .grant(grant), .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr),
    .dbg_state_o(dbg_state)
  );

  // ---------------- shared bench state ----------------
  int checks = 0;
  int failures = 0;
  int tick_div = 1250;
  logic hold0 = 1'b0, hold1 = 1'b0;
  logic mon_en = 1'b0;
  logic mon_in_flight = 1'b0;

  logic [8:0]   drv_q0[$], drv_q1[$];   // {last, byte} per requester
  int           tx_out_q[$];             // done delay per started byte
  logic [W-1:0] exp_q[$];

  // reference model state
  logic [8:0] m_q0[$], m_q1[$];
  int         m_out[$];
  int         m_last_served = 1;
  int         m_owner = 0;
  logic       m_lock = 1'b0;
  logic       m_err = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Serve order from the arbitration rules: owner while locked, otherwise the
  // lone requester with data, otherwise the one not served last.
  task automatic model_run();
    int g;
    int d;
    logic [8:0] e;
    while (m_q0.size() + m_q1.size() > 0) begin
      if (m_lock) g = m_owner;
      else if (m_q0.size() > 0 && m_q1.size() > 0) g = (m_last_served == 1) ? 0 : 1;
      else g = (m_q0.size() > 0) ? 0 : 1;
      if ((g == 0 && m_q0.size() == 0) || (g == 1 && m_q1.size() == 0)) break;
      e = (g == 1) ? m_q1.pop_front() : m_q0.pop_front();
      d = (m_out.size() > 0) ? m_out.pop_front() : 3;
      if (d == 0) begin
        m_err  = 1'b1;
        m_lock = 1'b0;
      end else begin
        m_lock = !e[8];
      end
      m_last_served = g;
      m_owner       = g;
      exp_q.push_back({4'(d), m_err, 1'(g), e[7:0]});
      tx_out_q.push_back(d);
    end
  endtask

  // ---------------- requester drivers ----------------
  initial begin : drv0
    logic acc;
    logic [8:0] tmp;
    forever begin
      @(negedge hwclk);
      acc = req0_valid && req0_ready;
      @(posedge hwclk);
      #1;
      if (acc && drv_q0.size() > 0) tmp = drv_q0.pop_front();
      req0_valid = (drv_q0.size() > 0) && !hold0;
      if (drv_q0.size() > 0) {req0_last, req0_byte} = drv_q0[0];
    end
  end

  initial begin : drv1
    logic acc;
    logic [8:0] tmp;
    forever begin
      @(negedge hwclk);
      acc = req1_valid && req1_ready;
      @(posedge hwclk);
      #1;
      if (acc && drv_q1.size() > 0) tmp = drv_q1.pop_front();
      req1_valid = (drv_q1.size() > 0) && !hold1;
      if (drv_q1.size() > 0) {req1_last, req1_byte} = drv_q1[0];
    end
  end

  // ---------------- baud tick + transmitter model ----------------
  initial begin : txm
    int tcnt = 0;
    int xs = 0;   // 0 idle, 1 start requested, 2 shifting
    int n = 0;
    int d = 0;
    forever begin
      @(posedge hwclk);
      #1;
      tx_done    = 1'b0;
      err_clr_tx = 1'b0;
      tcnt++;
      if (tcnt >= tick_div) tcnt = 0;
      baud_tick = (tcnt == 0);
      if (!rst_n) begin
        xs = 0;
      end else begin
        if (xs == 0) begin
          if (tx_send) begin
            d  = (tx_out_q.size() > 0) ? tx_out_q.pop_front() : 3;
            xs = 1;
          end else if ($urandom_range(15) == 0) begin
            tx_done = 1'b1;   // stray pulse while idle must be ignored
          end
        end else if (xs == 1) begin
          if (!tx_send) begin
            xs = 2;
            n  = 0;
          end else if ($urandom_range(5) == 0) begin
            tx_done = 1'b1;   // stray pulse during the start request
          end
        end
        if (xs == 2) begin
          if (!busy) begin
            xs = 0;
          end else if (baud_tick) begin
            n++;
            if (d != 0 && n == d) begin
              tx_done = 1'b1;
              xs = 0;
            end else if (d == 0 && n == TIMEOUT && $urandom_range(1) == 1) begin
              err_clr_tx = 1'b1;  // clear racing the timeout set
            end
          end
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [W-1:0] cur;
    logic chk_pend, prev_send, prev_busy, prev_tick;
    int wticks;
    int dly;
    cur = '0; chk_pend = 0; prev_send = 0; prev_busy = 0; prev_tick = 0; wticks = 0;
    forever begin
      @(negedge hwclk);
      if (!mon_en || !rst_n) begin
        exp_q.delete();
        mon_in_flight = 1'b0;
        chk_pend = 0; prev_send = 0; prev_busy = 0; prev_tick = 0;
      end else begin
        if (req0_valid && req1_valid) check("ready_exclusive", req0_ready & req1_ready, 0);
        if (chk_pend) begin
          check("tx_byte", tx_byte, cur[7:0]);
          check("grant", grant, cur[8]);
          check("tx_send_latency", tx_send, 1);
          check("busy_in_send", busy, 1);
          check("ready_one_cycle", req0_ready | req1_ready, 0);
          chk_pend = 0;
        end
        if (mon_in_flight) begin
          if (prev_send && !tx_send && busy) check("send_exit_on_tick", prev_tick, 1);
          if (prev_busy && !busy) begin
            dly = (cur[13:10] == 0) ? TIMEOUT : int'(cur[13:10]);
            check("err_after_byte", err_timeout, cur[9]);
            check("wait_ticks", wticks, dly);
            check("grant_hold", grant, cur[8]);
            check("byte_hold", tx_byte, cur[7:0]);
            mon_in_flight = 1'b0;
          end else if (busy && !tx_send && baud_tick) begin
            wticks++;
          end
        end
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
          check("xfer_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check("xfer_requester", req1_ready, cur[8]);
            mon_in_flight = 1'b1;
            chk_pend = 1;
            wticks = 0;
          end
        end
        prev_send = tx_send;
        prev_busy = busy;
        prev_tick = baud_tick;
      end
    end
  end

  // ---------------- main sequence helpers ----------------
  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge hwclk);
      n++;
    end while (!(drv_q0.size() == 0 && drv_q1.size() == 0 && exp_q.size() == 0 &&
                 !busy && !mon_in_flight) && n < LIMIT);
    check({tag, "_idle_reached"}, n < LIMIT, 1);
  endtask

  task automatic clear_err();
    @(negedge hwclk);
    check("err_before_clr", err_timeout, m_err);
    @(posedge hwclk); #1 err_clr_main = 1'b1;
    @(posedge hwclk); #1 err_clr_main = 1'b0;
    @(negedge hwclk);
    check("err_cleared", err_timeout, 0);
    m_err = 1'b0;
  endtask

  task automatic load(input logic [8:0] t0[$], input logic [8:0] t1[$], input int o[$]);
    m_q0 = t0;
    m_q1 = t1;
    m_out = o;
    model_run();
    drv_q0 = t0;
    drv_q1 = t1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [8:0] t0[$], t1[$];
    int o[$];
    int n;

    // reset state
    repeat (3) @(negedge hwclk);
    check("rst_tx_send", tx_send, 0);
    check("rst_tx_byte", tx_byte, 8'h00);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_timeout, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge hwclk);

    // single byte 0x41 from req0, slow baud
    t0 = '{{1'b1, 8'h41}}; t1 = {}; o = '{10};
    load(t0, t1, o);
    wait_idle("single");
    check("single_grant", grant, 0);
    check("single_byte", tx_byte, 8'h41);
    check("single_state", dbg_state, 0);

    // round robin, both valid, single-byte messages
    tick_div = 8;
    t0 = '{{1'b1, 8'hA0}, {1'b1, 8'hA1}};
    t1 = '{{1'b1, 8'hB0}, {1'b1, 8'hB1}};
    o = '{4, 4, 4, 4};
    load(t0, t1, o);
    wait_idle("round_robin");

    // lock: req0 message 0x10,0x11 with a gap; req1 must wait
    t0 = '{{1'b0, 8'h10}}; t1 = {}; o = '{5};
    load(t0, t1, o);
    n = 0;
    do begin @(negedge hwclk); n++; end while (exp_q.size() != 0 && n < LIMIT);
    check("lock_first_accept", n < LIMIT, 1);
    hold0 = 1'b1;
    m_q0 = '{{1'b1, 8'h11}}; m_q1 = '{{1'b1, 8'h77}}; m_out = '{3, 3};
    model_run();
    drv_q0.push_back({1'b1, 8'h11});
    drv_q1.push_back({1'b1, 8'h77});
    repeat (150) @(negedge hwclk);
    if (!busy && req1_valid) check("lock_stall", req1_ready, 0);
    hold0 = 1'b0;
    wait_idle("lock");

    // timeout mid-message clears the lock and sets the error
    t0 = '{{1'b0, 8'h20}, {1'b1, 8'h21}};
    t1 = '{{1'b1, 8'h30}};
    o = '{0, 4, 4};
    load(t0, t1, o);
    wait_idle("timeout");
    check("timeout_err_set", err_timeout, 1);
    clear_err();

    // done on the same tick as the timeout: no error
    t0 = {}; t1 = '{{1'b1, 8'h55}}; o = '{12};
    load(t0, t1, o);
    wait_idle("coincident");
    check("coincident_no_err", err_timeout, 0);

    // randomized traffic
    for (int p = 0; p < 6; p++) begin
      tick_div = $urandom_range(20, 4);
      clear_err();
      t0 = {}; t1 = {}; o = {};
      for (int r = 0; r < 2; r++) begin
        int nm = $urandom_range(3, 1);
        for (int m = 0; m < nm; m++) begin
          int len = $urandom_range(3, 1);
          for (int b = 0; b < len; b++) begin
            logic [8:0] e;
            e = {(b == len - 1), 8'($urandom_range(255, 0))};
            if (r == 0) t0.push_back(e); else t1.push_back(e);
          end
        end
      end
      for (int k = 0; k < t0.size() + t1.size(); k++) begin
        int rr = $urandom_range(19, 0);
        if (rr < 3) o.push_back(0);
        else if (rr < 5) o.push_back(12);
        else o.push_back($urandom_range(11, 1));
      end
      load(t0, t1, o);
      wait_idle("random");
    end

    // asynchronous reset in the middle of WAIT
    tick_div = 8;
    mon_en = 1'b0;
    drv_q0.push_back({1'b1, 8'hC0});
    drv_q0.push_back({1'b1, 8'hC1});
    tx_out_q.push_back(0);
    n = 0;
    do begin @(negedge hwclk); n++; end while (!(busy && !tx_send) && n < LIMIT);
    check("reach_wait", n < LIMIT, 1);
    repeat (3) @(negedge hwclk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx_send", tx_send, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_ready0", req0_ready, 0);
    check("async_rst_tx_byte", tx_byte, 8'h00);
    check("async_rst_err", err_timeout, 0);
    drv_q0.delete();
    drv_q1.delete();
    tx_out_q.delete();
    m_last_served = 1;
    m_owner = 0;
    m_lock = 1'b0;
    m_err = 1'b0;
    repeat (3) @(negedge hwclk);
    check("rst_hold_ready0", req0_ready, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge hwclk);
    t0 = '{{1'b1, 8'hD0}}; t1 = '{{1'b1, 8'hD1}}; o = '{2, 2};
    load(t0, t1, o);
    wait_idle("after_reset");
    check("after_reset_last_grant", grant, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
